// File: rtl/sram_master_port.sv
// Byte-to-word bridge between a radio byte stream and a 16-bit SRAM controller
// port: packs RX bytes into writes, unpacks reads into TX bytes, one request at a time.
module sram_master_port #(
  parameter int HINT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_wr,
  input  logic        rx_flush,
  output logic        rx_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_take,
  output logic        master_write,
  output logic        master_read,
  output logic [15:0] master_data_to_sram,
  input  logic [15:0] master_data_from_sram,
  input  logic        master_hint,
  input  logic        fifo_i_empty,
  input  logic        fifo_o_full,
  output logic        rx_overflow,
  output logic        timeout_err,
  output logic [15:0] words_written,
  output logic [15:0] words_read
);

  localparam int TW = (HINT_TIMEOUT > 1) ? $clog2(HINT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(HINT_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   pack_q, pack_d;
  logic          half_q, half_d;
  logic          pend_q, pend_d;
  logic [15:0]   txw_q, txw_d;
  logic [1:0]    txn_q, txn_d;
  logic          ovf_q, ovf_d;
  logic          terr_q, terr_d;
  logic [15:0]   nwr_q, nwr_d;
  logic [15:0]   nrd_q, nrd_d;

  logic wr_go, rd_go, tmo_hit, wr_done, rd_done;

  // Writes win over reads; a read is only launched into an empty TX buffer.
  assign wr_go   = pend_q && !fifo_o_full;
  assign rd_go   = (txn_q == 2'd0) && !fifo_i_empty && !wr_go;
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign wr_done = (state_q == WR_REQ) && master_hint;
  assign rd_done = (state_q == RD_REQ) && master_hint;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_go)      state_d = WR_REQ;
        else if (rd_go) state_d = RD_REQ;
      end
      WR_REQ, RD_REQ: begin
        if (master_hint || tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tmo_d = (state_q != IDLE && state_d != IDLE) ? tmo_q + 1'b1 : '0;
  end

  always_comb begin
    master_write = (state_q == WR_REQ);
    master_read  = (state_q == RD_REQ);
  end

  always_comb begin
    pack_d = pack_q;
    half_d = half_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    txw_d  = txw_q;
    txn_d  = txn_q;
    terr_d = terr_q;
    nwr_d  = nwr_q;
    nrd_d  = nrd_q;

    if (rx_byte_wr) begin
      if (pend_q) begin
        ovf_d = 1'b1;
      end else if (!half_q) begin
        pack_d = {rx_byte, 8'h00};
        half_d = 1'b1;
      end else begin
        pack_d[7:0] = rx_byte;
        half_d      = 1'b0;
        pend_d      = 1'b1;
      end
    end
    // Flush sees the result of any byte packed in the same cycle.
    if (rx_flush && half_d) begin
      pack_d[7:0] = 8'h00;
      half_d      = 1'b0;
      pend_d      = 1'b1;
    end

    if (wr_done) begin
      pend_d = 1'b0;
      nwr_d  = nwr_q + 16'd1;
    end

    if (tx_take && txn_q != 2'd0) txn_d = txn_q - 2'd1;
    if (rd_done) begin
      txw_d = master_data_from_sram;
      txn_d = 2'd2;
      nrd_d = nrd_q + 16'd1;
    end

    // A timeout leaves pend_q/txn_q untouched so IDLE simply retries.
    if (state_q != IDLE && !master_hint && tmo_hit) terr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pack_q <= '0;
      half_q <= 1'b0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      txw_q  <= '0;
      txn_q  <= 2'd0;
      terr_q <= 1'b0;
      nwr_q  <= '0;
      nrd_q  <= '0;
    end else begin
      pack_q <= pack_d;
      half_q <= half_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      txw_q  <= txw_d;
      txn_q  <= txn_d;
      terr_q <= terr_d;
      nwr_q  <= nwr_d;
      nrd_q  <= nrd_d;
    end
  end

  assign rx_ready            = !pend_q;
  assign tx_valid            = (txn_q != 2'd0);
  assign tx_byte             = (txn_q == 2'd2) ? txw_q[15:8] :
                               (txn_q == 2'd1) ? txw_q[7:0]  : 8'h00;
  assign master_data_to_sram = pack_q;
  assign rx_overflow         = ovf_q;
  assign timeout_err         = terr_q;
  assign words_written       = nwr_q;
  assign words_read          = nrd_q;

endmodule

// File: tb/tb_sram_master_port.sv
// Bench for sram_master_port: RX packing table, directed handshake/timeout/reset
// sequences, and a randomized run against a queue-based transfer model.
module tb_sram_master_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_byte_wr = 1'b0;
  logic        rx_flush = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_take = 1'b0;
  logic        master_write;
  logic        master_read;
  logic [15:0] master_data_to_sram;
  logic [15:0] master_data_from_sram = 16'h0000;
  logic        master_hint = 1'b0;
  logic        fifo_i_empty = 1'b1;
  logic        fifo_o_full = 1'b1;
  logic        rx_overflow;
  logic        timeout_err;
  logic [15:0] words_written;
  logic [15:0] words_read;

  int total = 0;
  int bad = 0;

  sram_master_port #(.HINT_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_byte(rx_byte), .rx_byte_wr(rx_byte_wr), .rx_flush(rx_flush), .rx_ready(rx_ready),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_take(tx_take),
    .master_write(master_write), .master_read(master_read),
    .master_data_to_sram(master_data_to_sram), .master_data_from_sram(master_data_from_sram),
    .master_hint(master_hint), .fifo_i_empty(fifo_i_empty), .fifo_o_full(fifo_o_full),
    .rx_overflow(rx_overflow), .timeout_err(timeout_err),
    .words_written(words_written), .words_read(words_read)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         rst;
    bit         wr;
    bit         fl;
    logic [7:0] b;
    bit         rdy;
    bit         ovf;
    bit         cd;
    logic [15:0] d;
  } vec_t;

  vec_t tbl[12];

  // random-run model state
  logic [15:0] wq[$];
  logic [7:0]  tq[$];
  logic [7:0]  hi;
  int          held;
  int          wait_n;
  bit          active;
  bit          last_hint;
  int          nwr;
  int          nrd;
  int          cnt;
  logic [31:0] expw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_byte_wr = 1'b0; rx_flush = 1'b0; tx_take = 1'b0; master_hint = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    rx_byte = b; rx_byte_wr = 1'b1; rx_flush = fl;
    step();
    rx_byte_wr = 1'b0; rx_flush = 1'b0;
  endtask

  task automatic wait_wr(input string nm);
    int n = 0;
    while (!master_write && n < 200) begin step(); n++; end
    chk(nm, master_write, 1'b1);
  endtask

  task automatic wait_rd(input string nm);
    int n = 0;
    while (!master_read && n < 200) begin step(); n++; end
    chk(nm, master_read, 1'b1);
  endtask

  task automatic chk_reset(input string p);
    chk({p, " master_write"}, master_write, 1'b0);
    chk({p, " master_read"}, master_read, 1'b0);
    chk({p, " data_to_sram"}, master_data_to_sram, 16'h0000);
    chk({p, " tx_byte"}, tx_byte, 8'h00);
    chk({p, " tx_valid"}, tx_valid, 1'b0);
    chk({p, " rx_ready"}, rx_ready, 1'b1);
    chk({p, " rx_overflow"}, rx_overflow, 1'b0);
    chk({p, " timeout_err"}, timeout_err, 1'b0);
    chk({p, " words_written"}, words_written, 16'h0000);
    chk({p, " words_read"}, words_read, 16'h0000);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 16'h7E00};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 16'h7E00};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0000};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 16'h1100};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0000};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 16'h2233};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 16'h2233};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1, 1'b1, 16'h2233};

    do_reset();
    chk_reset("reset");

    // RX packing table, SRAM side held off so words stay pending
    fifo_o_full = 1'b1; fifo_i_empty = 1'b1;
    foreach (tbl[i]) begin
      rst_n = !tbl[i].rst; rx_byte_wr = tbl[i].wr; rx_flush = tbl[i].fl; rx_byte = tbl[i].b;
      step();
      rst_n = 1'b1; rx_byte_wr = 1'b0; rx_flush = 1'b0;
      chk($sformatf("vec%0d rx_ready", i), rx_ready, tbl[i].rdy);
      chk($sformatf("vec%0d rx_overflow", i), rx_overflow, tbl[i].ovf);
      if (tbl[i].cd) chk($sformatf("vec%0d data", i), master_data_to_sram, tbl[i].d);
    end

    // write handshake: hint three cycles after master_write rises
    do_reset();
    fifo_o_full = 1'b0; fifo_i_empty = 1'b1;
    send(8'hA5, 1'b0); send(8'h3C, 1'b0);
    chk("A rx_ready low", rx_ready, 1'b0);
    wait_wr("A write start");
    chk("A data", master_data_to_sram, 16'hA53C);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (master_write) cnt++;
      master_hint = (k == 3);
      step();
    end
    master_hint = 1'b0;
    chk("A write cycles", cnt, 4);
    chk("A words_written", words_written, 16'd1);
    chk("A rx_ready back", rx_ready, 1'b1);

    // stray hint in IDLE, read unpacking, reread latency, reset mid-read
    do_reset();
    fifo_o_full = 1'b1; fifo_i_empty = 1'b1;
    master_hint = 1'b1; step(); master_hint = 1'b0; step();
    chk("B stray words_written", words_written, 16'd0);
    chk("B stray words_read", words_read, 16'd0);
    chk("B stray tx_valid", tx_valid, 1'b0);
    fifo_i_empty = 1'b0;
    wait_rd("B read start");
    master_data_from_sram = 16'h1234; master_hint = 1'b1;
    step();
    master_hint = 1'b0; master_data_from_sram = 16'h0000;
    chk("B tx_valid", tx_valid, 1'b1);
    chk("B tx_byte hi", tx_byte, 8'h12);
    chk("B read dropped", master_read, 1'b0);
    chk("B words_read", words_read, 16'd1);
    tx_take = 1'b1; step(); tx_take = 1'b0;
    chk("B tx_byte lo", tx_byte, 8'h34);
    chk("B tx_valid lo", tx_valid, 1'b1);
    tx_take = 1'b1; step(); tx_take = 1'b0;
    chk("B tx_valid empty", tx_valid, 1'b0);
    chk("B read not yet", master_read, 1'b0);
    step();
    chk("B reread", master_read, 1'b1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    fifo_i_empty = 1'b1;
    chk("B rst master_read", master_read, 1'b0);
    chk("B rst tx_valid", tx_valid, 1'b0);
    chk("B rst words_read", words_read, 16'd0);
    chk("B rst words_written", words_written, 16'd0);

    // write priority over read
    do_reset();
    fifo_o_full = 1'b1; fifo_i_empty = 1'b1;
    send(8'hC0, 1'b0); send(8'hDE, 1'b0); step();
    chk("C held off", master_write, 1'b0);
    fifo_o_full = 1'b0; fifo_i_empty = 1'b0;
    step();
    chk("C write first", master_write, 1'b1);
    chk("C no read yet", master_read, 1'b0);
    master_hint = 1'b1; step(); master_hint = 1'b0;
    chk("C gap write", master_write, 1'b0);
    chk("C gap read", master_read, 1'b0);
    step();
    chk("C read after", master_read, 1'b1);
    master_data_from_sram = 16'hBEEF; master_hint = 1'b1; step(); master_hint = 1'b0;
    fifo_i_empty = 1'b1;
    chk("C tx_byte", tx_byte, 8'hBE);
    chk("C words_written", words_written, 16'd1);
    chk("C words_read", words_read, 16'd1);

    // timeout and retry of the same word
    do_reset();
    fifo_o_full = 1'b0; fifo_i_empty = 1'b1;
    send(8'h5A, 1'b0); send(8'hC3, 1'b0);
    wait_wr("E write start");
    chk("E no timeout yet", timeout_err, 1'b0);
    cnt = 0;
    for (int k = 0; k < 100 && master_write; k++) begin cnt++; step(); end
    chk("E timeout cycles", cnt, 64);
    chk("E timeout_err", timeout_err, 1'b1);
    chk("E word kept", rx_ready, 1'b0);
    wait_wr("E retry");
    chk("E retry data", master_data_to_sram, 16'h5AC3);
    master_hint = 1'b1; step(); master_hint = 1'b0;
    chk("E words_written", words_written, 16'd1);
    chk("E rx_ready", rx_ready, 1'b1);
    chk("E timeout sticky", timeout_err, 1'b1);

    // randomized traffic against the transfer model
    do_reset();
    held = 0; wait_n = 0; active = 1'b0; last_hint = 1'b0; nwr = 0; nrd = 0;
    for (int c = 0; c < 1500; c++) begin
      fifo_o_full  = ($urandom_range(0, 3) == 0);
      fifo_i_empty = ($urandom_range(0, 1) == 0);
      rx_byte_wr = 1'b0; rx_flush = 1'b0; tx_take = 1'b0; master_hint = 1'b0;

      chk("rnd rx_ready", rx_ready, wq.size() == 0);
      chk("rnd tx_valid", tx_valid, tq.size() != 0);
      chk("rnd one req", master_write & master_read, 1'b0);
      if (last_hint) chk("rnd req drop", master_write | master_read, 1'b0);
      if (active) chk("rnd req held", master_write | master_read, 1'b1);
      last_hint = 1'b0;

      if (wq.size() == 0 && $urandom_range(0, 1) == 1) begin
        rx_byte = 8'($urandom); rx_byte_wr = 1'b1;
        if (held == 0) begin hi = rx_byte; held = 1; end
        else begin wq.push_back({hi, rx_byte}); held = 0; end
      end
      if ($urandom_range(0, 9) == 0) begin
        rx_flush = 1'b1;
        if (held == 1) begin wq.push_back({hi, 8'h00}); held = 0; end
      end

      if (tq.size() != 0 && $urandom_range(0, 2) == 0) begin
        chk("rnd tx_byte", tx_byte, tq[0]);
        void'(tq.pop_front());
        tx_take = 1'b1;
      end else if (tq.size() == 0 && $urandom_range(0, 7) == 0) begin
        tx_take = 1'b1;
      end

      if (master_write || master_read) begin
        if (!active) begin active = 1'b1; wait_n = $urandom_range(0, 5); end
        if (wait_n == 0) begin
          master_hint = 1'b1; active = 1'b0; last_hint = 1'b1;
          if (master_write) begin
            expw = (wq.size() != 0) ? {16'h0000, wq[0]} : 32'hDEAD0000;
            chk("rnd wr word", master_data_to_sram, expw);
            if (wq.size() != 0) void'(wq.pop_front());
            nwr++;
          end else begin
            master_data_from_sram = 16'($urandom);
            tq.push_back(master_data_from_sram[15:8]);
            tq.push_back(master_data_from_sram[7:0]);
            nrd++;
          end
        end else begin
          wait_n--;
        end
      end
      step();
    end
    rx_byte_wr = 1'b0; rx_flush = 1'b0; tx_take = 1'b0; master_hint = 1'b0;
    chk("rnd words_written", words_written, 16'(nwr));
    chk("rnd words_read", words_read, 16'(nrd));
    chk("rnd rx_overflow", rx_overflow, 1'b0);
    chk("rnd timeout_err", timeout_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
